g_4nand_arb: RTL and testbench

G_4NAND_ARB -- requirements
Module: g_4nand_arb

---
 rtl/g_4nand_arb_pkg.sv | 26 ++
 rtl/g_4nand_arb_if.sv | 15 +
 rtl/g_4nand_arb_nand.sv | 11 +
 rtl/g_4nand_arb.sv | 102 ++++++++++
 tb/tb_g_4nand_arb.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/g_4nand_arb_pkg.sv
// Shared types and constants for the round-robin arbitrated 4-input NAND evaluator.
package g_4nand_arb_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned OPW  = 4;
  localparam int unsigned IDXW = 2;

  typedef logic [OPW-1:0]  operand_t;
  typedef logic [IDXW-1:0] idx_t;
  typedef logic [NREQ-1:0] reqvec_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EVAL    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Pointer reset value makes requester 0 the first candidate after reset
  localparam idx_t LAST_RST = idx_t'(NREQ - 1);

  function automatic reqvec_t idx2oh(input idx_t i);
    idx2oh = reqvec_t'(1) << i;
  endfunction

endpackage

// File: rtl/g_4nand_arb_if.sv
// Requester-side bus of the arbiter: requests, operands, grant/ack and result.
interface g_4nand_arb_if;
  import g_4nand_arb_pkg::*;

  reqvec_t             req;
  operand_t [NREQ-1:0] din;
  reqvec_t             gnt;
  reqvec_t             ack;
  logic                yn;
  logic                busy;

  modport master (output req, din, input gnt, ack, yn, busy);
  modport slave  (input req, din, output gnt, ack, yn, busy);

endinterface

// File: rtl/g_4nand_arb_nand.sv
// Library 4-input NAND cell used as the shared evaluation resource.
module g_4nand_arb_nand
  import g_4nand_arb_pkg::*;
(
  input  operand_t opnd_i,
  output logic     yn_c_o
);

  assign yn_c_o = ~&opnd_i;

endmodule

// File: rtl/g_4nand_arb.sv
// Round-robin arbiter sharing one 4-input NAND among four requesters.
module g_4nand_arb
  import g_4nand_arb_pkg::*;
(
  input logic          ck_i,
  input logic          cd_i,
  g_4nand_arb_if.slave bus
);

  state_e   state_q, state_d;
  reqvec_t  gnt_q, gnt_d;
  reqvec_t  ack_q, ack_d;
  logic     yn_q, yn_d;
  logic     busy_q, busy_d;
  operand_t opnd_q, opnd_d;
  idx_t     last_q, last_d;
  idx_t     win_q, win_d;
  idx_t     pick;
  logic     nand_y;

  // First asserted request searching upward from last+1; smallest offset wins
  function automatic idx_t rr_pick(input reqvec_t req, input idx_t last);
    idx_t cand;
    rr_pick = last;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      cand = idx_t'(32'(last) + k);
      if (req[cand]) rr_pick = cand;
    end
  endfunction

  g_4nand_arb_nand u_g_4nand (
    .opnd_i (opnd_q),
    .yn_c_o (nand_y)
  );

  always_ff @(posedge ck_i) begin
    if (cd_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      yn_q    <= 1'b1;
      busy_q  <= 1'b0;
      opnd_q  <= '0;
      last_q  <= LAST_RST;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      yn_q    <= yn_d;
      busy_q  <= busy_d;
      opnd_q  <= opnd_d;
      last_q  <= last_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    yn_d    = yn_q;
    opnd_d  = opnd_q;
    last_d  = last_q;
    win_d   = win_q;
    pick    = rr_pick(bus.req, last_q);

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d = ST_EVAL;
          win_d   = pick;
          gnt_d   = idx2oh(pick);
          opnd_d  = bus.din[pick];
        end
      end
      // Result and acknowledge become visible together on entry to RESP
      ST_EVAL: begin
        yn_d    = nand_y;
        ack_d   = gnt_q;
        last_d  = win_q;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!bus.req[win_q]) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.yn   = yn_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_g_4nand_arb.sv
// Directed bench for g_4nand_arb: transaction-level model compared every cycle plus literal checkpoints.
module tb_g_4nand_arb;

  logic ck;
  logic cd;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 0;

  g_4nand_arb_if ifc ();

  g_4nand_arb dut (
    .ck_i (ck),
    .cd_i (cd),
    .bus  (ifc)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Model: phase counts cycles since grant (0 = no transaction in flight)
  int         m_phase = 0;
  int         m_w     = 0;
  int         m_last  = 3;
  logic [3:0] m_cap   = 4'h0;
  logic       m_yn    = 1'b1;

  function automatic int rr(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return last;
  endfunction

  always @(posedge ck) begin
    if (cd) begin
      m_phase <= 0;
      m_w     <= 0;
      m_last  <= 3;
      m_cap   <= 4'h0;
      m_yn    <= 1'b1;
    end else begin
      case (m_phase)
        0: if (ifc.req != 4'b0) begin
          m_w     <= rr(ifc.req, m_last);
          m_cap   <= ifc.din[rr(ifc.req, m_last)];
          m_phase <= 1;
        end
        1: begin
          m_yn    <= (m_cap != 4'hF);
          m_last  <= m_w;
          m_phase <= 2;
        end
        2: m_phase <= 3;
        default: if (!ifc.req[m_w]) m_phase <= 0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge ck) begin
    if (chk_en) begin
      check("gnt_model",  ifc.gnt,  (m_phase != 0) ? (32'd1 << m_w) : 32'd0);
      check("ack_model",  ifc.ack,  (m_phase == 2) ? (32'd1 << m_w) : 32'd0);
      check("yn_model",   ifc.yn,   m_yn);
      check("busy_model", ifc.busy, (m_phase != 0));
      check("gnt_onehot0", $onehot0(ifc.gnt), 1);
      check("ack_onehot0", $onehot0(ifc.ack), 1);
      check("ack_eq_gnt", (ifc.ack == 4'b0) || (ifc.ack == ifc.gnt), 1);
    end
  end

  task automatic wait_ack(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge ck);
      if (ifc.ack != 4'b0) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: ack not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge ck);
      if (!ifc.busy) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: busy still high after %0d cycles", name, budget);
    end
  endtask

  int         ord    [5] = '{0, 1, 2, 3, 0};
  logic       yn_ord [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    cd      = 1'b1;
    ifc.req = 4'b0;
    ifc.din = '0;
    repeat (2) @(negedge ck);
    chk_en = 1;
    check("rst_gnt", ifc.gnt, 0);
    check("rst_ack", ifc.ack, 0);
    check("rst_yn", ifc.yn, 1);
    check("rst_busy", ifc.busy, 0);

    // Single request from reset: grant next cycle, ack and result the cycle after
    cd         = 1'b0;
    ifc.req    = 4'b0001;
    ifc.din[0] = 4'hF;
    @(negedge ck);
    check("t1_gnt", ifc.gnt, 4'b0001);
    check("t1_ack_early", ifc.ack, 0);
    @(negedge ck);
    check("t1_ack", ifc.ack, 4'b0001);
    check("t1_yn", ifc.yn, 0);
    ifc.req[0] = 1'b0;
    @(negedge ck);
    check("t1_gnt_hold", ifc.gnt, 4'b0001);
    check("t1_ack_once", ifc.ack, 0);
    @(negedge ck);
    check("t1_busy_low", ifc.busy, 0);
    check("t1_gnt_clr", ifc.gnt, 0);

    // All four requesting: round-robin order from reset pointer, including wrap
    cd = 1'b1;
    @(negedge ck);
    cd         = 1'b0;
    ifc.din[0] = 4'hF;
    ifc.din[1] = 4'h7;
    ifc.din[2] = 4'hF;
    ifc.din[3] = 4'h0;
    ifc.req    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_ack("t2_wait", 20);
      check("t2_ack_order", ifc.ack, 32'd1 << ord[i]);
      check("t2_yn", ifc.yn, yn_ord[i]);
      if (i == 4) ifc.req = 4'b0;
      else ifc.req[ord[i]] = 1'b0;
      wait_idle("t2_idle", 20);
      if (i < 4) ifc.req = 4'hF;
    end

    // Granted requester holding REQ blocks re-service and the pending requester
    ifc.req = 4'b0100;
    wait_ack("t3_wait2", 20);
    check("t3_ack2", ifc.ack, 4'b0100);
    ifc.req = 4'b1100;
    repeat (5) begin
      @(negedge ck);
      check("t3_hold_gnt", ifc.gnt, 4'b0100);
      check("t3_no_ack", ifc.ack, 0);
      check("t3_busy", ifc.busy, 1);
    end
    ifc.req[2] = 1'b0;
    wait_ack("t3_wait3", 20);
    check("t3_gnt3", ifc.gnt, 4'b1000);
    check("t3_ack3", ifc.ack, 4'b1000);
    check("t3_yn3", ifc.yn, 1);
    ifc.req = 4'b0;
    wait_idle("t3_idle", 20);

    // Operand change after capture must not affect the result
    ifc.req    = 4'b0010;
    ifc.din[1] = 4'hF;
    @(negedge ck);
    check("t4_gnt", ifc.gnt, 4'b0010);
    ifc.din[1] = 4'h0;
    @(negedge ck);
    check("t4_ack", ifc.ack, 4'b0010);
    check("t4_yn_captured", ifc.yn, 0);
    ifc.req = 4'b0;
    wait_idle("t4_idle", 20);

    // Reset during EVAL aborts; pointer restarts at requester 0
    ifc.req    = 4'b0100;
    ifc.din[2] = 4'hF;
    @(negedge ck);
    check("t5_gnt", ifc.gnt, 4'b0100);
    cd = 1'b1;
    @(negedge ck);
    check("t5_no_ack", ifc.ack, 0);
    check("t5_gnt_clr", ifc.gnt, 0);
    check("t5_yn_rst", ifc.yn, 1);
    check("t5_busy", ifc.busy, 0);
    cd         = 1'b0;
    ifc.din[0] = 4'hE;
    ifc.req    = 4'b0101;
    wait_ack("t5_wait0", 20);
    check("t5_ack0", ifc.ack, 4'b0001);
    check("t5_yn0", ifc.yn, 1);
    ifc.req[0] = 1'b0;
    wait_ack("t5_wait2", 20);
    check("t5_ack2", ifc.ack, 4'b0100);
    check("t5_yn2", ifc.yn, 0);
    ifc.req = 4'b0;
    wait_idle("t5_idle", 20);

    repeat (2) @(negedge ck);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
